// File: rtl/pcie_8b10b_pkg.sv
// Shared 8b/10b definitions for the PCIe Rx lane decoder.
//   K-code byte values ({HGF,EDCBA}) for the twelve legal control symbols.
//   ones10(): popcount of a 10-bit symbol, used for disparity classification.
package pcie_8b10b_pkg;

  localparam logic [7:0] K28_0 = 8'h1C;
  localparam logic [7:0] K28_1 = 8'h3C;
  localparam logic [7:0] K28_2 = 8'h5C;
  localparam logic [7:0] K28_3 = 8'h7C;
  localparam logic [7:0] K28_4 = 8'h9C;
  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K28_6 = 8'hDC;
  localparam logic [7:0] K28_7 = 8'hFC;
  localparam logic [7:0] K23_7 = 8'hF7;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;
  localparam logic [7:0] K30_7 = 8'hFE;

  function automatic logic [3:0] ones10(input logic [9:0] sym);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 10; i++) n = n + {3'b000, sym[i]};
    return n;
  endfunction

endpackage

// File: rtl/dec_8b10b_sym.sv
// Combinational single-symbol 8b/10b decoder.
//   sym      in  10  {a,b,c,d,e,i,f,g,h,j}, a = bit 9
//   rd_in    in  1   incoming running disparity (0 = RD-, 1 = RD+)
//   data     out 8   decoded byte {HGF,EDCBA}, 0x00 on code error
//   is_k     out 1   legal K-code
//   comma    out 1   K28.1, K28.5 or K28.7
//   code_err out 1   not a legal data or K symbol
//   disp_err out 1   legal symbol whose disparity is illegal for rd_in
//   rd_out   out 1   running disparity after this symbol
module dec_8b10b_sym
  import pcie_8b10b_pkg::*;
(
  input  logic [9:0] sym,
  input  logic       rd_in,
  output logic [7:0] data,
  output logic       is_k,
  output logic       comma,
  output logic       code_err,
  output logic       disp_err,
  output logic       rd_out
);

  logic [3:0] ones;
  logic [5:0] s6;
  logic [3:0] s4;
  logic       k_hit, hit6, hit4;
  logic [7:0] k_byte;
  logic [4:0] d5;
  logic [2:0] d3;
  logic       pos, neg, bal, is_comma, comma_rd;

  assign ones = ones10(sym);
  assign s6   = sym[9:4];
  assign s4   = sym[3:0];
  assign pos  = (ones == 4'd6);
  assign neg  = (ones == 4'd4);
  assign bal  = (ones == 4'd5);

  always_comb begin
    k_hit  = 1'b1;
    k_byte = '0;
    case (sym)
      10'b0011110100, 10'b1100001011: k_byte = K28_0;
      10'b0011111001, 10'b1100000110: k_byte = K28_1;
      10'b0011110101, 10'b1100001010: k_byte = K28_2;
      10'b0011110011, 10'b1100001100: k_byte = K28_3;
      10'b0011110010, 10'b1100001101: k_byte = K28_4;
      10'b0011111010, 10'b1100000101: k_byte = K28_5;
      10'b0011110110, 10'b1100001001: k_byte = K28_6;
      10'b0011111000, 10'b1100000111: k_byte = K28_7;
      10'b1110101000, 10'b0001010111: k_byte = K23_7;
      10'b1101101000, 10'b0010010111: k_byte = K27_7;
      10'b1011101000, 10'b0100010111: k_byte = K29_7;
      10'b0111101000, 10'b1000010111: k_byte = K30_7;
      default:                        k_hit  = 1'b0;
    endcase
  end

  always_comb begin
    hit6 = 1'b1;
    d5   = '0;
    case (s6)
      6'b100111, 6'b011000: d5 = 5'd0;
      6'b011101, 6'b100010: d5 = 5'd1;
      6'b101101, 6'b010010: d5 = 5'd2;
      6'b110001:            d5 = 5'd3;
      6'b110101, 6'b001010: d5 = 5'd4;
      6'b101001:            d5 = 5'd5;
      6'b011001:            d5 = 5'd6;
      6'b111000, 6'b000111: d5 = 5'd7;
      6'b111001, 6'b000110: d5 = 5'd8;
      6'b100101:            d5 = 5'd9;
      6'b010101:            d5 = 5'd10;
      6'b110100:            d5 = 5'd11;
      6'b001101:            d5 = 5'd12;
      6'b101100:            d5 = 5'd13;
      6'b011100:            d5 = 5'd14;
      6'b010111, 6'b101000: d5 = 5'd15;
      6'b011011, 6'b100100: d5 = 5'd16;
      6'b100011:            d5 = 5'd17;
      6'b010011:            d5 = 5'd18;
      6'b110010:            d5 = 5'd19;
      6'b001011:            d5 = 5'd20;
      6'b101010:            d5 = 5'd21;
      6'b011010:            d5 = 5'd22;
      6'b111010, 6'b000101: d5 = 5'd23;
      6'b110011, 6'b001100: d5 = 5'd24;
      6'b100110:            d5 = 5'd25;
      6'b010110:            d5 = 5'd26;
      6'b110110, 6'b001001: d5 = 5'd27;
      6'b001110:            d5 = 5'd28;
      6'b101110, 6'b010001: d5 = 5'd29;
      6'b011110, 6'b100001: d5 = 5'd30;
      6'b101011, 6'b010100: d5 = 5'd31;
      default:              hit6 = 1'b0;
    endcase
  end

  always_comb begin
    hit4 = 1'b1;
    d3   = '0;
    case (s4)
      4'b1011, 4'b0100:                   d3 = 3'd0;
      4'b1001:                            d3 = 3'd1;
      4'b0101:                            d3 = 3'd2;
      4'b1100, 4'b0011:                   d3 = 3'd3;
      4'b1101, 4'b0010:                   d3 = 3'd4;
      4'b1010:                            d3 = 3'd5;
      4'b0110:                            d3 = 3'd6;
      4'b1110, 4'b0001, 4'b0111, 4'b1000: d3 = 3'd7;
      default:                            hit4 = 1'b0;
    endcase
  end

  // A data symbol can have legal sub-blocks yet 3 or 7 ones overall,
  // so the popcount gate is applied on top of the table hits.
  assign code_err = ~(pos | neg | bal) | ~(k_hit | (hit6 & hit4));
  assign is_comma = k_hit & ((k_byte == K28_1) | (k_byte == K28_5) | (k_byte == K28_7));

  // Comma resync: the RD- form (abcdei = 001111) leaves RD+ when unbalanced
  // and RD- when balanced (K28.7); the RD+ form is the mirror image.
  assign comma_rd = (s6 == 6'b001111) ? ~bal : bal;

  assign data     = code_err ? 8'h00 : (k_hit ? k_byte : {d3, d5});
  assign is_k     = k_hit & ~code_err;
  assign comma    = is_comma & ~code_err;
  assign disp_err = ~code_err & ~is_comma & ((pos & rd_in) | (neg & ~rd_in));

  always_comb begin
    rd_out = rd_in;
    if (!code_err) begin
      if (is_comma) rd_out = comma_rd;
      else if (pos) rd_out = 1'b1;
      else if (neg) rd_out = 1'b0;
    end
  end

endmodule

// File: rtl/decode_10_to_8_multi.sv
// Multi-symbol 8b/10b decoder, NUM_SYM symbols per clock, RD chained across
// symbols (symbol 0 earliest on the wire), registered outputs, latency 1.
//   clk, rst          clock, async active-high reset
//   in_valid, data_in NUM_SYM aligned 10-bit symbols
//   rd_load(_val)     override incoming RD of symbol 0 (or RD itself when idle)
//   err_cnt_clr       clear the error counter (same-beat errors still counted)
//   out_valid, data_out, is_kcode, comma_det, code_err, disp_err  per-symbol results
//   rd_out            RD after the last symbol of the most recent valid beat
//   err_cnt           saturating count of errored symbols
module decode_10_to_8_multi
  import pcie_8b10b_pkg::*;
#(
  parameter int NUM_SYM   = 2,
  parameter int ERR_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [10*NUM_SYM-1:0]  data_in,
  input  logic                   rd_load,
  input  logic                   rd_load_val,
  input  logic                   err_cnt_clr,
  output logic                   out_valid,
  output logic [8*NUM_SYM-1:0]   data_out,
  output logic [NUM_SYM-1:0]     is_kcode,
  output logic [NUM_SYM-1:0]     comma_det,
  output logic [NUM_SYM-1:0]     code_err,
  output logic [NUM_SYM-1:0]     disp_err,
  output logic                   rd_out,
  output logic [ERR_CNT_W-1:0]   err_cnt
);

  localparam int SUM_W = ERR_CNT_W + 3;

  logic                 rd_q;
  logic [NUM_SYM:0]     rd_chain;
  logic [8*NUM_SYM-1:0] dec_data;
  logic [NUM_SYM-1:0]   dec_k, dec_comma, dec_cerr, dec_derr, sym_err;
  logic [2:0]           beat_errs;
  logic [SUM_W-1:0]     cnt_base, cnt_sum;
  logic [ERR_CNT_W-1:0] cnt_next;

  assign rd_chain[0] = rd_load ? rd_load_val : rd_q;

  for (genvar k = 0; k < NUM_SYM; k++) begin : g_sym
    dec_8b10b_sym u_sym (
      .sym      (data_in[10*k +: 10]),
      .rd_in    (rd_chain[k]),
      .data     (dec_data[8*k +: 8]),
      .is_k     (dec_k[k]),
      .comma    (dec_comma[k]),
      .code_err (dec_cerr[k]),
      .disp_err (dec_derr[k]),
      .rd_out   (rd_chain[k+1])
    );
  end

  assign sym_err = dec_cerr | dec_derr;

  always_comb begin
    beat_errs = '0;
    for (int k = 0; k < NUM_SYM; k++) beat_errs = beat_errs + {2'b00, sym_err[k]};
  end

  // Clear and accumulate in one step so a clear never drops the beat's errors.
  always_comb begin
    cnt_base = err_cnt_clr ? '0 : {3'b000, err_cnt};
    cnt_sum  = cnt_base + {{(SUM_W-3){1'b0}}, beat_errs};
    cnt_next = (|cnt_sum[SUM_W-1:ERR_CNT_W]) ? '1 : cnt_sum[ERR_CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q      <= 1'b0;
      out_valid <= 1'b0;
      data_out  <= '0;
      is_kcode  <= '0;
      comma_det <= '0;
      code_err  <= '0;
      disp_err  <= '0;
      rd_out    <= 1'b0;
      err_cnt   <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        rd_q      <= rd_chain[NUM_SYM];
        rd_out    <= rd_chain[NUM_SYM];
        data_out  <= dec_data;
        is_kcode  <= dec_k;
        comma_det <= dec_comma;
        code_err  <= dec_cerr;
        disp_err  <= dec_derr;
        err_cnt   <= cnt_next;
      end else begin
        if (rd_load)     rd_q    <= rd_load_val;
        if (err_cnt_clr) err_cnt <= '0;
      end
    end
  end

endmodule
